// File: rtl/path_delay_pkg.sv
// Shared types and helpers for the tapped delay-chain TDC.
// Holds the FSM state encoding, the count-width rule and the tap popcount.
package path_delay_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      LAUNCH = 3'd2,
      CAPT   = 3'd3,
      SYNC   = 3'd4,
      ACC    = 3'd5,
      DONE   = 3'd6
   } state_e;

   // Widest tap vector popcount accepts; chains up to 256 stages.
   localparam int PC_W = 256;

   function automatic int cnt_width(input int stages);
      return $clog2(stages + 1);
   endfunction

   function automatic logic [8:0] popcount(input logic [PC_W-1:0] v);
      logic [8:0] n;
      n = '0;
      for (int i = 0; i < PC_W; i++) n = n + 9'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/path_delay_tdc_if.sv
// Control/result bundle between the TDC and its readout logic.
// start is sampled only while busy=0; busy rises on the accepting edge and falls
// when DONE is left; done pulses one cycle and results hold until the next start.
interface path_delay_tdc_if #(
   parameter int CNT_W      = 6,
   parameter int LOG_TRIALS = 2
);
   localparam int SUM_W = CNT_W + LOG_TRIALS;

   logic             start;
   logic [CNT_W-1:0] golden;
   logic [CNT_W-1:0] tolerance;
   logic             busy;
   logic             done;
   logic [SUM_W-1:0] delay_sum;
   logic [CNT_W-1:0] delay_avg;
   logic             alarm;
   logic             ovf;
   logic [2:0]       dbg_state;

   modport master (
      output start, golden, tolerance,
      input  busy, done, delay_sum, delay_avg, alarm, ovf, dbg_state
   );

   modport slave (
      input  start, golden, tolerance,
      output busy, done, delay_sum, delay_avg, alarm, ovf, dbg_state
   );
endinterface

// File: rtl/delay_chain_tapped.sv
// Chain of STAGES delay cells with every stage output brought out as a tap.
// Each stage owns its nets so synthesis keeps one distinct cell per stage.
module delay_chain_tapped #(
   parameter int STAGES = 50
) (
   input  logic              launch_i,
   output logic [STAGES-1:0] taps
);
   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      (* keep *) logic in_w;
      (* keep *) logic out_w;
      if (i == 0) begin : g_first
         assign in_w = launch_i;
      end else begin : g_rest
         assign in_w = g_stage[i-1].out_w;
      end
      singlepath_2 u_stage (
         .in_i  (in_w),
         .en_i  (1'b1),
         .dis_i (1'b0),
         .out_o (out_w)
      );
      assign taps[i] = out_w;
   end
endmodule

// File: rtl/singlepath_2.sv
// Behavioural view of one non-inverting delay cell; the physical cell supplies the delay.
module singlepath_2 (
   input  logic in_i,
   input  logic en_i,
   input  logic dis_i,
   output logic out_o
);
   assign out_o = in_i & en_i & ~dis_i;
endmodule

// File: rtl/path_delay_tdc.sv
// Tapped delay-chain TDC: launches alternating edges, captures the taps one clock
// later, averages bubble-tolerant stage counts and flags excess path delay.
module path_delay_tdc
   import path_delay_pkg::*;
#(
   parameter int STAGES        = 50,
   parameter int LOG_TRIALS    = 2,
   parameter int SETTLE_CYCLES = 8,
   parameter int CNT_W         = cnt_width(STAGES)
) (
   input logic             clk,
   input logic             rst,
   path_delay_tdc_if.slave bus
);
   localparam int SUM_W   = CNT_W + LOG_TRIALS;
   localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);
   localparam int TRL_W   = LOG_TRIALS + 1;
   localparam int NTRIALS = 1 << LOG_TRIALS;

   localparam logic [2:0] S_IDLE   = 3'(IDLE);
   localparam logic [2:0] S_SETTLE = 3'(SETTLE);
   localparam logic [2:0] S_LAUNCH = 3'(LAUNCH);
   localparam logic [2:0] S_CAPT   = 3'(CAPT);
   localparam logic [2:0] S_SYNC   = 3'(SYNC);
   localparam logic [2:0] S_ACC    = 3'(ACC);
   localparam logic [2:0] S_DONE   = 3'(DONE);

   logic [2:0]        state_q, state_d;
   logic [SET_W-1:0]  settle_q, settle_d;
   logic              sync_q, sync_d;
   logic [TRL_W-1:0]  trial_q, trial_d;
   logic              launch_q, launch_d;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [CNT_W-1:0]  avg_q, avg_d;
   logic              alarm_q, alarm_d;
   logic              ovf_q, ovf_d;
   logic [STAGES-1:0] cap_q, sync1_q, sync2_q;

   (* keep *) logic [STAGES-1:0] taps_w;

   delay_chain_tapped #(.STAGES(STAGES)) u_chain (
      .launch_i (launch_q),
      .taps     (taps_w)
   );

   // Stages that already followed the launched level; bubbles count, no first-zero search.
   logic [STAGES-1:0] sel_w;
   logic [CNT_W-1:0]  trial_cnt;
   logic [SUM_W-1:0]  acc_sum;
   logic [CNT_W-1:0]  avg_new, diff_new;
   logic              alarm_new;

   assign sel_w     = launch_q ? sync2_q : ~sync2_q;
   assign trial_cnt = CNT_W'(popcount(PC_W'(sel_w)));
   assign acc_sum   = sum_q + SUM_W'(trial_cnt);
   assign avg_new   = CNT_W'(acc_sum >> LOG_TRIALS);
   assign diff_new  = (avg_new > bus.golden) ? avg_new - bus.golden : bus.golden - avg_new;
   assign alarm_new = diff_new > bus.tolerance;

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      sync_d   = sync_q;
      trial_d  = trial_q;
      launch_d = launch_q;
      sum_d    = sum_q;
      avg_d    = avg_q;
      alarm_d  = alarm_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d  = S_SETTLE;
               settle_d = '0;
               trial_d  = '0;
               sum_d    = '0;
               alarm_d  = 1'b0;
               ovf_d    = 1'b0;
               // An odd trial count leaves the chain high; restart low so trial 0 rises.
               launch_d = 1'b0;
            end
         end
         S_SETTLE: begin
            if (settle_q == SET_W'(SETTLE_CYCLES - 1)) state_d = S_LAUNCH;
            else settle_d = settle_q + 1'b1;
         end
         S_LAUNCH: begin
            launch_d = ~launch_q;
            state_d  = S_CAPT;
         end
         S_CAPT: begin
            sync_d  = 1'b0;
            state_d = S_SYNC;
         end
         S_SYNC: begin
            if (sync_q) state_d = S_ACC;
            else sync_d = 1'b1;
         end
         S_ACC: begin
            sum_d   = acc_sum;
            trial_d = trial_q + 1'b1;
            if (trial_cnt == CNT_W'(STAGES)) ovf_d = 1'b1;
            if (trial_q == TRL_W'(NTRIALS - 1)) begin
               state_d = S_DONE;
               avg_d   = avg_new;
               alarm_d = alarm_new;
            end else begin
               state_d  = S_SETTLE;
               settle_d = '0;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         settle_q <= '0;
         sync_q   <= 1'b0;
         trial_q  <= '0;
         launch_q <= 1'b0;
         sum_q    <= '0;
         avg_q    <= '0;
         alarm_q  <= 1'b0;
         ovf_q    <= 1'b0;
         cap_q    <= '0;
         sync1_q  <= '0;
         sync2_q  <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         sync_q   <= sync_d;
         trial_q  <= trial_d;
         launch_q <= launch_d;
         sum_q    <= sum_d;
         avg_q    <= avg_d;
         alarm_q  <= alarm_d;
         ovf_q    <= ovf_d;
         if (state_q == S_CAPT) cap_q <= taps_w;
         sync1_q  <= cap_q;
         sync2_q  <= sync1_q;
      end
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.delay_sum = sum_q;
   assign bus.delay_avg = avg_q;
   assign bus.alarm     = alarm_q;
   assign bus.ovf       = ovf_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_path_delay_tdc.sv
// Directed bench for path_delay_tdc: a stage-per-period chain model drives the taps,
// expected results are queued at start and checked when done pulses.
module tb_path_delay_tdc;
   import path_delay_pkg::*;

   localparam int STAGES = 50;
   localparam int CNT_W  = 6;

   typedef struct packed {
      logic [7:0] sum;
      logic [5:0] avg;
      logic       alarm;
      logic       ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   path_delay_tdc_if #(.CNT_W(CNT_W), .LOG_TRIALS(2)) bus0 ();
   path_delay_tdc_if #(.CNT_W(CNT_W), .LOG_TRIALS(0)) bus1 ();

   path_delay_tdc #(.STAGES(STAGES), .LOG_TRIALS(2), .SETTLE_CYCLES(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   path_delay_tdc #(.STAGES(STAGES), .LOG_TRIALS(0), .SETTLE_CYCLES(8)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   int n_checks = 0;
   int n_fail   = 0;
   exp_t exp_q[$];
   int last_avg = 0;

   // Physical chain model: for one period after an edge, the first spp taps follow it.
   int rise_spp = 17;
   int fall_spp = 17;
   logic model_lvl = 1'b0;
   logic [STAGES-1:0] model_taps = '0;
   logic [STAGES-1:0] bubble = 50'h17FF;

   always @(negedge clk) begin
      logic lvl;
      int spp;
      lvl = dut.launch_q;
      if (lvl != model_lvl) begin
         spp = lvl ? rise_spp : fall_spp;
         for (int i = 0; i < STAGES; i++) model_taps[i] = (i < spp) ? lvl : ~lvl;
         model_lvl = lvl;
      end else begin
         model_taps = {STAGES{lvl}};
      end
      force dut.taps_w = model_taps;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int s);
      return (s > STAGES) ? STAGES : s;
   endfunction

   function automatic exp_t model(input int r, input int f, input int g, input int t, input int log_t);
      exp_t e;
      int sum, avg, c, d;
      bit ov;
      sum = 0;
      ov  = 1'b0;
      for (int k = 0; k < (1 << log_t); k++) begin
         c = (k % 2 == 0) ? sat(r) : sat(f);
         if (c == STAGES) ov = 1'b1;
         sum += c;
      end
      avg = sum >> log_t;
      d   = (avg > g) ? avg - g : g - avg;
      e.sum   = 8'(sum);
      e.avg   = 6'(avg);
      e.alarm = (d > t);
      e.ovf   = ov;
      return e;
   endfunction

   task automatic measure(input int r, input int f, input int g, input int t);
      exp_t e;
      int cyc;
      bit seen;
      rise_spp = r;
      fall_spp = f;
      bus0.golden    = 6'(g);
      bus0.tolerance = 6'(t);
      exp_q.push_back(model(r, f, g, t, 2));
      bus0.start = 1'b1;
      @(posedge clk); #1;
      bus0.start = 1'b0;
      check("busy_after_start", 32'(bus0.busy), 1);
      check("sum_cleared", 32'(bus0.delay_sum), 0);
      check("ovf_cleared", 32'(bus0.ovf), 0);
      check("alarm_cleared", 32'(bus0.alarm), 0);
      check("avg_held", 32'(bus0.delay_avg), 32'(last_avg));
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if (bus0.done) seen = 1'b1;
      end
      check("done_seen", 32'(seen), 1);
      check("done_edge", 32'(cyc), 52);
      e = exp_q.pop_front();
      check("delay_sum", 32'(bus0.delay_sum), 32'(e.sum));
      check("delay_avg", 32'(bus0.delay_avg), 32'(e.avg));
      check("alarm", 32'(bus0.alarm), 32'(e.alarm));
      check("ovf", 32'(bus0.ovf), 32'(e.ovf));
      last_avg = int'(e.avg);
      @(posedge clk); #1;
      check("done_pulse_end", 32'(bus0.done), 0);
      check("busy_end", 32'(bus0.busy), 0);
   endtask

   initial begin
      exp_t e;
      int cyc;
      bit seen;
      bus0.start = 1'b0; bus0.golden = '0; bus0.tolerance = '0;
      bus1.start = 1'b0; bus1.golden = '0; bus1.tolerance = '0;
      force dut1.taps_w = bubble;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus0.busy), 0);
      check("rst_done", 32'(bus0.done), 0);
      check("rst_sum", 32'(bus0.delay_sum), 0);
      check("rst_avg", 32'(bus0.delay_avg), 0);
      check("rst_alarm", 32'(bus0.alarm), 0);
      check("rst_ovf", 32'(bus0.ovf), 0);
      check("rst_state", 32'(bus0.dbg_state), 32'(IDLE));
      rst = 1'b0;
      @(posedge clk); #1;

      measure(17, 17, 17, 1);
      measure(20, 20, 17, 1);
      measure(17, 15, 17, 1);
      measure(60, 60, 17, 1);
      measure(17, 17, 17, 1);

      // Single-trial instance with a captured bubble below the edge front.
      bus1.golden    = 6'd12;
      bus1.tolerance = 6'd0;
      exp_q.push_back(model($countones(bubble), $countones(bubble), 12, 0, 0));
      bus1.start = 1'b1;
      @(posedge clk); #1;
      bus1.start = 1'b0;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         if (bus1.done) seen = 1'b1;
      end
      check("bubble_done_seen", 32'(seen), 1);
      check("bubble_done_edge", 32'(cyc), 13);
      e = exp_q.pop_front();
      check("bubble_sum", 32'(bus1.delay_sum), 32'(e.sum));
      check("bubble_avg", 32'(bus1.delay_avg), 32'(e.avg));
      check("bubble_alarm", 32'(bus1.alarm), 32'(e.alarm));
      check("bubble_ovf", 32'(bus1.ovf), 32'(e.ovf));

      // Start while busy is ignored; reset mid-trial clears everything at once.
      rise_spp = 17; fall_spp = 17;
      bus0.golden = 6'd17; bus0.tolerance = 6'd1;
      bus0.start = 1'b1;
      @(posedge clk); #1;
      bus0.start = 1'b0;
      cyc = 0;
      while (bus0.dbg_state !== 3'(SYNC) && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("sync_reached", 32'(bus0.dbg_state), 32'(SYNC));
      bus0.start = 1'b1;
      @(posedge clk); #1;
      bus0.start = 1'b0;
      check("start_ignored_busy", 32'(bus0.busy), 1);
      check("start_ignored_state", 32'(bus0.dbg_state), 32'(SYNC));
      rst = 1'b1;
      #1;
      check("arst_busy", 32'(bus0.busy), 0);
      check("arst_done", 32'(bus0.done), 0);
      check("arst_sum", 32'(bus0.delay_sum), 0);
      check("arst_avg", 32'(bus0.delay_avg), 0);
      check("arst_alarm", 32'(bus0.alarm), 0);
      check("arst_ovf", 32'(bus0.ovf), 0);
      check("arst_state", 32'(bus0.dbg_state), 32'(IDLE));
      @(posedge clk); #1;
      rst = 1'b0;
      last_avg = 0;
      @(posedge clk); #1;
      measure(17, 17, 17, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
